layer_motion_updater: RTL
=========================

// Module: layer_motion_updater
// PURPOSE
//  Controller-side writer for the layer header store. On each frameStart it walks layers 0..NUM_LAYERS-1
//  over the ctrl r/w port, integrating sprite X/Y velocity into X/Y position and stepping the animation frame.
//  Writes results back before pixel processing begins. Top-level muxes this port against the host while busy=1.
// PARAMETERS
//  NUM_LAYERS     32  layers scanned per frame (1..32)
//  VEL_FRAC_BITS  4   fractional bits of velocity; velocity = signed px/frame, Q(16-F).F
//  ANIM_DIV       4   video frames per animation step (>=1)
// PORTS
//  clk                 in   1   GPU clock
//  reset               in   1   synchronous, active-high reset
//  frameStart          in   1   1-cycle pulse, start of new video frame
//  ctrlReadData        in   16  header register read data (combinational from index/layer, same cycle)
//  ctrlReadWriteLayer  out  5   layer being accessed
//  layerRegisterIndex  out  3   register index being accessed
//  writeLayerData      out  16  write data
//  writeLayerEn        out  1   write strobe, store captures on the next posedge
//  busy                out  1   scan in progress, owns ctrl port
//  done                out  1   1-cycle pulse, scan complete
//  frameOverrun        out  1   1-cycle pulse, frameStart arrived while busy
// BEHAVIOUR
//  Reset: all outputs 0; FSM=IDLE; layer counter=0; anim divider=0; all per-layer fractional accumulators=0.
//  All outputs are decoded from registered state; no combinational path from any input to any output.
//  Every FSM state lasts exactly 1 cycle. In RD_* states, index/layer are presented and ctrlReadData is captured at the edge.
//  States: IDLE -> FLAGS -> XVEL(5) -> XPOS(3) -> XWR(3) -> YVEL(6) -> YPOS(4) -> YWR(4) -> ANRD(7) -> ANWR(7) -> NEXT.
//   IDLE: on frameStart set busy=1, layer=0, animTick=(divider==ANIM_DIV-1), divider=(divider+1) mod ANIM_DIV.
//   FLAGS (reg 0): if bit0==0 (unpopulated) or bit1==0 (text) go to NEXT, so the layer takes 1 cycle.
//   YWR -> ANRD only if flags bit3 (animated) && animTick; otherwise YWR -> NEXT.
//   NEXT is merged into the last state: the layer increments in the same edge. After layer NUM_LAYERS-1: IDLE, busy=0, done=1.
//  Cycles per layer: 1 (skip) / 7 (sprite) / 9 (sprite, animation step).
//  Position math, per axis: acc = {pos[15:0], frac[F-1:0]} + sext(vel) in 16+F bits, wrapping modulo 2^(16+F).
//   Write pos=acc[15+F:F]; store frac=acc[F-1:0] for that layer and axis (arithmetic floor toward -inf).
//   The write happens even when vel==0.
//  Animation, reg 7: num=[7:0], cur=[15:8]. New cur = (num<=1 || cur+1>=num) ? 0 : cur+1. [7:0] is written back unchanged.
//  frameStart while busy: ignored, no restart, frameOverrun=1 for 1 cycle. frameStart coincident with done: ignored, frameOverrun=1.
//  writeLayerEn is high only in XWR/YWR/ANWR. Index and layer are stable in the strobe cycle.
//  Reset mid-scan: the next cycle has writeLayerEn=0, busy=0; the in-flight write is dropped; the next frameStart restarts at layer 0.
//  The fractional accumulator of a layer is not cleared on resetLayer. The host re-writes position to resync.
// TESTING
//  T1 reset; all layers flags=0; frameStart -> busy high 32 cycles, done pulse on cycle 33, writeLayerEn never high.
//  T2 L3 sprite X=100 XVel=0x0010 Y=50 YVel=0xFFF8 -> after frame1 X=101 Y=49; after frame2 X=102 Y=49; frac(Y)=0.
//  T3 L5 sprite+animated num=3 cur=2, ANIM_DIV=4 -> cur unchanged frames 1-3; after frame4 reg7=0x0003; L5 is 9 cycles only in frame4.
//  T4 L0 X=0x7FFF XVel=0x0010 -> X=0x8000; XVel=0xFFF0 from X=0 -> X=0xFFFF.
//  T5 frameStart again 5 cycles into scan -> frameOverrun pulse, single done, each layer updated exactly once.
//  T6 reset at layer 10 XWR -> no write that cycle+1, busy=0; new frameStart -> first access layer 0 reg 0, fracs zero.

Source files
------------

// File: rtl/layer_motion_updater_if.sv
// Ctrl-port bundle between the motion updater and the layer header store.
// The updater is the master: it drives layer/index/write and reads header data back combinationally.
interface layer_motion_updater_if;
    logic        frameStart;
    logic [15:0] ctrlReadData;
    logic [4:0]  ctrlReadWriteLayer;
    logic [2:0]  layerRegisterIndex;
    logic [15:0] writeLayerData;
    logic        writeLayerEn;
    logic        busy;
    logic        done;
    logic        frameOverrun;

    modport master (
        input  frameStart,
        input  ctrlReadData,
        output ctrlReadWriteLayer,
        output layerRegisterIndex,
        output writeLayerData,
        output writeLayerEn,
        output busy,
        output done,
        output frameOverrun
    );

    modport slave (
        output frameStart,
        output ctrlReadData,
        input  ctrlReadWriteLayer,
        input  layerRegisterIndex,
        input  writeLayerData,
        input  writeLayerEn,
        input  busy,
        input  done,
        input  frameOverrun
    );
endinterface

// File: rtl/layer_motion_updater.sv
// Per-frame walker over the layer header store: integrates sprite velocity into position
// and steps the animation frame, writing results back before pixel processing starts.
module layer_motion_updater #(
    parameter int NUM_LAYERS    = 32,
    parameter int VEL_FRAC_BITS = 4,
    parameter int ANIM_DIV      = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    layer_motion_updater_if.master bus
);
    localparam int ACC_W = 16 + VEL_FRAC_BITS;
    localparam int DIV_W = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
    localparam logic [4:0]       LAST_LAYER = 5'(NUM_LAYERS - 1);
    localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(ANIM_DIV - 1);

    typedef enum logic [3:0] {
        IDLE, FLAGS, XVEL, XPOS, XWR, YVEL, YPOS, YWR, ANRD, ANWR
    } stateT;

    typedef struct packed {
        logic [2:0] regIndex;
        logic       writeEn;
        logic       busy;
    } ctlT;

    // Position is {pos, frac}; velocity shares the fractional LSB, so a plain wrap-around add
    // gives floor-toward-minus-infinity behaviour on the fractional part.
    function automatic logic [ACC_W-1:0] integrate(input logic [15:0] pos,
                                                   input logic [VEL_FRAC_BITS-1:0] frac,
                                                   input logic signed [15:0] v);
        logic signed [ACC_W-1:0] vExt;
        vExt = {{VEL_FRAC_BITS{v[15]}}, v};
        return {pos, frac} + vExt;
    endfunction

    function automatic logic [15:0] animStep(input logic [15:0] r);
        logic [7:0] num;
        logic [7:0] cur;
        logic [7:0] nxt;
        num = r[7:0];
        cur = r[15:8];
        if (num <= 8'd1 || ({1'b0, cur} + 9'd1) >= {1'b0, num}) nxt = 8'd0;
        else nxt = cur + 8'd1;
        return {nxt, num};
    endfunction

    function automatic ctlT ctlFor(input stateT s);
        ctlT c;
        c.busy    = (s != IDLE);
        c.writeEn = (s == XWR) || (s == YWR) || (s == ANWR);
        case (s)
            XVEL:       c.regIndex = 3'd5;
            XPOS, XWR:  c.regIndex = 3'd3;
            YVEL:       c.regIndex = 3'd6;
            YPOS, YWR:  c.regIndex = 3'd4;
            ANRD, ANWR: c.regIndex = 3'd7;
            default:    c.regIndex = 3'd0;
        endcase
        return c;
    endfunction

    stateT                    state;
    ctlT                      ctl;
    logic [4:0]               layer;
    logic [DIV_W-1:0]         animDiv;
    logic                     animTick;
    logic                     animated;
    logic                     doneReg;
    logic                     overrunReg;
    logic signed [15:0]       vel;
    logic [15:0]              wrData;
    logic [VEL_FRAC_BITS-1:0] fracX [32];
    logic [VEL_FRAC_BITS-1:0] fracY [32];

    logic                     lastLayer;
    stateT                    advState;
    logic [VEL_FRAC_BITS-1:0] fracSel;
    logic [ACC_W-1:0]         acc;

    assign lastLayer = (layer == LAST_LAYER);
    assign advState  = lastLayer ? IDLE : FLAGS;

    always_comb begin
        fracSel = (state == YPOS) ? fracY[layer] : fracX[layer];
        acc     = integrate(bus.ctrlReadData, fracSel, vel);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            ctl        <= '0;
            layer      <= '0;
            animDiv    <= '0;
            animTick   <= 1'b0;
            animated   <= 1'b0;
            doneReg    <= 1'b0;
            overrunReg <= 1'b0;
            vel        <= '0;
            wrData     <= '0;
            for (int i = 0; i < 32; i++) begin
                fracX[i] <= '0;
                fracY[i] <= '0;
            end
        end else begin
            // A start pulse in the done cycle is treated like one arriving mid-scan.
            overrunReg <= bus.frameStart && ((state != IDLE) || doneReg);
            doneReg    <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.frameStart && !doneReg) begin
                        state    <= FLAGS;
                        ctl      <= ctlFor(FLAGS);
                        layer    <= '0;
                        animTick <= (animDiv == DIV_LAST);
                        animDiv  <= (animDiv == DIV_LAST) ? '0 : animDiv + 1'b1;
                    end
                end
                FLAGS: begin
                    animated <= bus.ctrlReadData[3];
                    if (bus.ctrlReadData[0] && bus.ctrlReadData[1]) begin
                        state <= XVEL;
                        ctl   <= ctlFor(XVEL);
                    end else begin
                        state   <= advState;
                        ctl     <= ctlFor(advState);
                        layer   <= lastLayer ? 5'd0 : layer + 5'd1;
                        doneReg <= lastLayer;
                    end
                end
                XVEL: begin
                    vel   <= bus.ctrlReadData;
                    state <= XPOS;
                    ctl   <= ctlFor(XPOS);
                end
                XPOS: begin
                    wrData       <= acc[ACC_W-1:VEL_FRAC_BITS];
                    fracX[layer] <= acc[VEL_FRAC_BITS-1:0];
                    state        <= XWR;
                    ctl          <= ctlFor(XWR);
                end
                XWR: begin
                    state <= YVEL;
                    ctl   <= ctlFor(YVEL);
                end
                YVEL: begin
                    vel   <= bus.ctrlReadData;
                    state <= YPOS;
                    ctl   <= ctlFor(YPOS);
                end
                YPOS: begin
                    wrData       <= acc[ACC_W-1:VEL_FRAC_BITS];
                    fracY[layer] <= acc[VEL_FRAC_BITS-1:0];
                    state        <= YWR;
                    ctl          <= ctlFor(YWR);
                end
                YWR: begin
                    if (animated && animTick) begin
                        state <= ANRD;
                        ctl   <= ctlFor(ANRD);
                    end else begin
                        state   <= advState;
                        ctl     <= ctlFor(advState);
                        layer   <= lastLayer ? 5'd0 : layer + 5'd1;
                        doneReg <= lastLayer;
                    end
                end
                ANRD: begin
                    wrData <= animStep(bus.ctrlReadData);
                    state  <= ANWR;
                    ctl    <= ctlFor(ANWR);
                end
                ANWR: begin
                    state   <= advState;
                    ctl     <= ctlFor(advState);
                    layer   <= lastLayer ? 5'd0 : layer + 5'd1;
                    doneReg <= lastLayer;
                end
                default: begin
                    state <= IDLE;
                    ctl   <= ctlFor(IDLE);
                end
            endcase
        end
    end

    assign bus.ctrlReadWriteLayer = layer;
    assign bus.layerRegisterIndex = ctl.regIndex;
    assign bus.writeLayerData     = wrData;
    assign bus.writeLayerEn       = ctl.writeEn;
    assign bus.busy               = ctl.busy;
    assign bus.done               = doneReg;
    assign bus.frameOverrun       = overrunReg;
endmodule
